// File: rtl/otter_branch_predictor.sv
// ---------------------------------------------------------------------------
// otter_branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters for the OTTER fetch stage. Fetch looks up the current PC
// combinationally. Decode trains the table with resolved branch/jump outcomes.
// Two saturating performance counters track resolved branches and
// mispredictions.
//
// Ports:
//   CLK              system clock, all state changes on the rising edge
//   RESET            synchronous active-high reset
//   FLUSH            clear every valid bit (fence.i / context change)
//   F_PC             fetch PC to look up
//   PRED_TAKEN       lookup hit whose counter predicts taken
//   PRED_TARGET      predicted target, zero unless PRED_TAKEN
//   UPD_VALID        a branch/jump resolved this cycle
//   UPD_PC           PC of the resolved instruction
//   UPD_UNCOND       1 = JAL/JALR, 0 = conditional branch
//   UPD_TAKEN        actual direction (treated as 1 for unconditional)
//   UPD_TARGET       actual target address
//   UPD_MISPRED      the prediction carried for this instruction was wrong
//   PERF_BRANCHES    saturating count of resolved updates
//   PERF_MISPREDICTS saturating count of mispredictions
// ---------------------------------------------------------------------------
module otter_branch_predictor #(
   parameter int ENTRIES      = 16,
   parameter int COUNTER_BITS = 2,
   parameter int PERF_W       = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic [31:0]       F_PC,
   output logic              PRED_TAKEN,
   output logic [31:0]       PRED_TARGET,
   input  logic              UPD_VALID,
   input  logic [31:0]       UPD_PC,
   input  logic              UPD_UNCOND,
   input  logic              UPD_TAKEN,
   input  logic [31:0]       UPD_TARGET,
   input  logic              UPD_MISPRED,
   output logic [PERF_W-1:0] PERF_BRANCHES,
   output logic [PERF_W-1:0] PERF_MISPREDICTS
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
   localparam logic [COUNTER_BITS-1:0] CNT_ZERO = '0;
   localparam logic [COUNTER_BITS-1:0] CNT_WEAK = COUNTER_BITS'(1 << (COUNTER_BITS - 1));

   // Table state. Valid bits are a flat vector so a flush clears them in one edge.
   logic [ENTRIES-1:0]      valid_q;
   logic [TAG_W-1:0]        tag_q    [ENTRIES];
   logic [29:0]             target_q [ENTRIES];
   logic [COUNTER_BITS-1:0] cnt_q    [ENTRIES];

   logic [PERF_W-1:0] perf_br_q;
   logic [PERF_W-1:0] perf_mp_q;

   // PC[1:0] never participates in indexing, tagging or target storage.
   logic unused_low_bits;
   assign unused_low_bits = ^{F_PC[1:0], UPD_PC[1:0], UPD_TARGET[1:0]};

   // -------------------------------------------------------------------------
   // Lookup
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx = F_PC[IDX_W+1:2];
   assign f_tag = F_PC[31:IDX_W+2];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   // Reads come straight from the registered table, so a same-cycle update
   // to this index is only seen on the following cycle.
   assign PRED_TAKEN  = !RESET && f_hit && cnt_q[f_idx][COUNTER_BITS-1];
   assign PRED_TARGET = PRED_TAKEN ? {target_q[f_idx], 2'b00} : 32'h0;

   // -------------------------------------------------------------------------
   // Update decode
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0]        u_idx;
   logic [TAG_W-1:0]        u_tag;
   logic                    u_hit;
   logic                    u_taken;
   logic [COUNTER_BITS-1:0] u_cnt;
   logic [COUNTER_BITS-1:0] u_cnt_next;
   logic                    tbl_wr;
   logic                    data_wr;

   assign u_idx   = UPD_PC[IDX_W+1:2];
   assign u_tag   = UPD_PC[31:IDX_W+2];
   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_taken = UPD_TAKEN | UPD_UNCOND;
   assign u_cnt   = cnt_q[u_idx];

   // A not-taken miss leaves the table alone; everything else touches the entry.
   assign tbl_wr  = UPD_VALID && (u_hit || u_taken);
   // Target (and tag, which is unchanged on a hit) is written for every taken update.
   assign data_wr = !RESET && !FLUSH && UPD_VALID && u_taken;

   always_comb begin
      // NOTE: default assignment first so no path leaves u_cnt_next unassigned (no latch).
      u_cnt_next = u_cnt;
      if (!u_hit) begin
         u_cnt_next = UPD_UNCOND ? CNT_MAX : CNT_WEAK;
      end else if (UPD_UNCOND) begin
         u_cnt_next = CNT_MAX;
      end else if (UPD_TAKEN) begin
         u_cnt_next = (u_cnt == CNT_MAX) ? u_cnt : u_cnt + COUNTER_BITS'(1);
      end else begin
         u_cnt_next = (u_cnt == CNT_ZERO) ? u_cnt : u_cnt - COUNTER_BITS'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Control state: valid bits, counters, perf counters
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= '0;
         end
         perf_br_q <= '0;
         perf_mp_q <= '0;
      end else begin
         // Perf counters count every reported update, even one dropped by FLUSH.
         if (UPD_VALID) begin
            if (perf_br_q != '1) begin
               perf_br_q <= perf_br_q + PERF_W'(1);
            end
            if (UPD_MISPRED && (perf_mp_q != '1)) begin
               perf_mp_q <= perf_mp_q + PERF_W'(1);
            end
         end

         if (FLUSH) begin
            valid_q <= '0;
         end else if (tbl_wr) begin
            valid_q[u_idx] <= 1'b1;
            cnt_q[u_idx]   <= u_cnt_next;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Payload storage: tags and targets
   // -------------------------------------------------------------------------
   // NOTE: tags and targets carry no reset; they are only observed behind a set valid bit.
   always_ff @(posedge CLK) begin
      if (data_wr) begin
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= UPD_TARGET[31:2];
      end
   end

   assign PERF_BRANCHES    = perf_br_q;
   assign PERF_MISPREDICTS = perf_mp_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_otter_branch_predictor
//
// Scoreboard bench for otter_branch_predictor (ENTRIES=16, COUNTER_BITS=2,
// PERF_W=4). The driver applies one cycle of stimulus at each falling edge,
// predicts the lookup and perf outputs from a table model and queues the
// prediction, then advances the model. A monitor samples the DUT shortly
// after each falling edge and compares against the queue.
// ---------------------------------------------------------------------------
module tb_otter_branch_predictor;

   localparam int ENTRIES = 16;
   localparam int CB      = 2;
   localparam int PW      = 4;
   localparam int CMAX    = (1 << CB) - 1;
   localparam int CWEAK   = 1 << (CB - 1);
   localparam int PMAX    = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          reset, flush;
   logic [31:0]   f_pc;
   logic          pred_taken;
   logic [31:0]   pred_target;
   logic          upd_valid, upd_uncond, upd_taken, upd_mispred;
   logic [31:0]   upd_pc, upd_target;
   logic [PW-1:0] perf_branches, perf_mispredicts;

   always #5 clk = ~clk;

   otter_branch_predictor #(.ENTRIES(ENTRIES), .COUNTER_BITS(CB), .PERF_W(PW)) dut (
      .CLK(clk), .RESET(reset), .FLUSH(flush), .F_PC(f_pc),
      .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target),
      .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_UNCOND(upd_uncond),
      .UPD_TAKEN(upd_taken), .UPD_TARGET(upd_target), .UPD_MISPRED(upd_mispred),
      .PERF_BRANCHES(perf_branches), .PERF_MISPREDICTS(perf_mispredicts)
   );

   // ---------------- reference model ----------------
   // The BTB as plain integer arrays; direction is "counter in upper half".
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   int          m_pb, m_pm;

   typedef struct {
      bit          pt;
      logic [31:0] tgt;
      int          pb;
      int          pm;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   // One clock cycle of stimulus. 'chk' = 0 only for the very first reset
   // cycle, where perf outputs are not yet defined.
   task automatic step(input bit rst, input bit fl, input logic [31:0] fpc,
                       input bit uv, input logic [31:0] upc, input bit unc,
                       input bit tk, input logic [31:0] tgt, input bit mp,
                       input bit chk);
      exp_t e;
      int   i;
      bit   hit, eff;
      @(negedge clk);
      reset = rst; flush = fl; f_pc = fpc;
      upd_valid = uv; upd_pc = upc; upd_uncond = unc;
      upd_taken = tk; upd_target = tgt; upd_mispred = mp;

      // Expected outputs from the state before this edge.
      i      = idx_of(fpc);
      hit    = m_valid[i] && (m_tag[i] == tag_of(fpc));
      e.pt   = !rst && hit && (m_cnt[i] >= CWEAK);
      e.tgt  = e.pt ? m_tgt[i] : 32'h0;
      e.pb   = m_pb;
      e.pm   = m_pm;
      if (chk) exp_q.push_back(e);

      // Advance the model across the coming edge.
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0;
            m_cnt[k]   = 0;
         end
         m_pb = 0;
         m_pm = 0;
      end else begin
         if (uv) begin
            m_pb = (m_pb + 1 > PMAX) ? PMAX : m_pb + 1;
            m_pm = (m_pm + int'(mp) > PMAX) ? PMAX : m_pm + int'(mp);
         end
         if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
         end else if (uv) begin
            i   = idx_of(upc);
            hit = m_valid[i] && (m_tag[i] == tag_of(upc));
            eff = tk || unc;
            if (hit) begin
               if (unc) m_cnt[i] = CMAX;
               else if (tk) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
               else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
               if (eff) m_tgt[i] = tgt & 32'hFFFF_FFFC;
            end else if (eff) begin
               m_valid[i] = 1;
               m_tag[i]   = tag_of(upc);
               m_tgt[i]   = tgt & 32'hFFFF_FFFC;
               m_cnt[i]   = unc ? CMAX : CWEAK;
            end
         end
      end
   endtask

   task automatic look(input logic [31:0] fpc);
      step(0, 0, fpc, 0, 32'h0, 0, 0, 32'h0, 0, 1);
   endtask

   task automatic upd(input logic [31:0] fpc, input logic [31:0] upc, input bit unc,
                      input bit tk, input logic [31:0] tgt, input bit mp);
      step(0, 0, fpc, 1, upc, unc, tk, tgt, mp, 1);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pred_taken",    {31'b0, pred_taken},         {31'b0, e.pt});
            check("pred_target",   pred_target,                 e.tgt);
            check("perf_branches", {28'b0, perf_branches},      32'(e.pb));
            check("perf_mispred",  {28'b0, perf_mispredicts},   32'(e.pm));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1; flush = 0; f_pc = 0; upd_valid = 0; upd_pc = 0;
      upd_uncond = 0; upd_taken = 0; upd_target = 0; upd_mispred = 0;

      // Reset and cold lookup
      step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1);
      look(32'h100);

      // Allocate at 0x100 (same-cycle lookup sees the old, empty entry), then train down
      upd(32'h100, 32'h100, 0, 1, 32'h180, 1);
      look(32'h100);
      upd(32'h100, 32'h100, 0, 0, 32'h0, 1);
      look(32'h100);
      upd(32'h100, 32'h100, 0, 0, 32'h0, 0);
      look(32'h100);
      for (int k = 0; k < 3; k++) upd(32'h100, 32'h100, 0, 0, 32'h0, 0);
      look(32'h100);
      upd(32'h100, 32'h100, 0, 1, 32'h184, 0);
      look(32'h100);
      upd(32'h100, 32'h100, 0, 1, 32'h188, 0);
      look(32'h100);

      // Tag conflict at index 0, then a not-taken miss that must not disturb it
      upd(32'h140, 32'h140, 0, 1, 32'h200, 1);
      look(32'h100);
      look(32'h140);
      upd(32'h140, 32'h180, 0, 0, 32'h300, 0);
      look(32'h140);
      look(32'h180);

      // Unconditional, then one not-taken conditional update (still taken)
      upd(32'h20, 32'h20, 1, 0, 32'h3C, 0);
      look(32'h20);
      upd(32'h20, 32'h20, 0, 0, 32'h0, 1);
      look(32'h20);
      upd(32'h20, 32'h20, 0, 0, 32'h0, 1);
      look(32'h22);

      // Flush together with an update: update dropped, perf still counts
      upd(32'h20, 32'h20, 1, 1, 32'h40, 0);
      step(0, 1, 32'h140, 1, 32'h60, 0, 1, 32'h90, 1, 1);
      look(32'h140);
      look(32'h20);
      look(32'h60);

      // Perf saturation, then reset with a concurrent update that is discarded
      for (int k = 0; k < 20; k++) upd(32'h100, 32'h100 + 32'(k * 4), k[0], 1, 32'h1000 + 32'(k * 8), 1);
      look(32'h104);
      step(1, 0, 32'h100, 1, 32'h100, 1, 1, 32'h500, 1, 1);
      look(32'h100);
      look(32'h104);

      // Randomized traffic over a small PC space so hits and conflicts are frequent
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] fpc, upc, tgt;
         bit rst, fl, uv;
         fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) upc = fpc;
         tgt = $urandom;
         rst = ($urandom_range(0, 99) < 2);
         fl  = ($urandom_range(0, 99) < 3);
         uv  = ($urandom_range(0, 99) < 60);
         step(rst, fl, fpc, uv, upc, ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
              tgt, $urandom_range(0, 1), 1);
      end
      look(32'h0);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      #5;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/otter_branch_predictor.md
Name: otter_branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with saturating-counter direction prediction for the pipelined OTTER fetch stage.
- Fetch queries it combinationally with the current fetch PC and gets a predicted-taken flag and target. The PC-source logic uses these to redirect fetch before decode resolves the branch.
- Decode reports resolved branch/jump outcomes back to train the tables.
- The block also keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..1024; IDX_W = $clog2(ENTRIES).
- COUNTER_BITS, 2, width of each direction counter; 1..4.
- PERF_W, 32, width of each performance counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  invalidate all entries (fence.i / context change).
- F_PC  input  32  fetch-stage PC (lookup address).
- PRED_TAKEN  output  1  lookup hit and predicted taken.
- PRED_TARGET  output  32  predicted target; valid only when PRED_TAKEN=1.
- UPD_VALID  input  1  a branch/jump resolved in decode this cycle.
- UPD_PC  input  32  PC of the resolved instruction.
- UPD_UNCOND  input  1  1 = JAL/JALR, 0 = conditional branch.
- UPD_TAKEN  input  1  actual outcome (forced to 1 when UPD_UNCOND=1).
- UPD_TARGET  input  32  actual target address.
- UPD_MISPRED  input  1  the prediction carried down the pipe for this instruction was wrong (direction or target).
- PERF_BRANCHES  output  PERF_W  resolved updates counted.
- PERF_MISPREDICTS  output  PERF_W  mispredictions counted.

Behaviour:
- Addressing:
  - index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]; PC[1:0] ignored.
  - Per entry: valid bit, tag, 30-bit target (target[31:2]; target[1:0] reconstructs as 00), COUNTER_BITS counter.
- Lookup (combinational from F_PC and registered state):
  - hit = valid[idx] & (tag[idx] == F_PC tag).
  - PRED_TAKEN = hit & counter[idx][MSB].
  - PRED_TARGET = {target[idx], 2'b00} when PRED_TAKEN, else 32'h0.
- Update (registered, takes effect on the edge ending the UPD_VALID cycle):
  - Effective taken = UPD_TAKEN | UPD_UNCOND.
  - Hit, conditional branch: counter +1 if taken (saturate at 2^COUNTER_BITS-1), -1 if not taken (saturate at 0). Target overwritten only if taken.
  - Hit, unconditional: counter set to max; target overwritten.
  - Miss, taken: allocate (replace the entry). Valid=1, new tag, target written. Counter = max if UPD_UNCOND, else weakly-taken 2^(COUNTER_BITS-1).
  - Miss, not taken: no allocation; table unchanged.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new state is visible the following cycle.
- Perf counters, on UPD_VALID:
  - PERF_BRANCHES += 1.
  - PERF_MISPREDICTS += UPD_MISPRED.
  - Both saturate at all-ones; no wrap.
- FLUSH: on the edge, all valid bits are cleared. Tags, targets, counters and perf counters are untouched. FLUSH and UPD_VALID in the same cycle: FLUSH wins, the update is dropped, but the perf counters still count it.
- RESET: on the edge, all valid bits, all counters and both perf counters go to 0.
  - While RESET=1, PRED_TAKEN=0, PRED_TARGET=0, and all updates and FLUSH are ignored.
  - Reset asserted mid-operation discards any same-cycle update.
  - The first lookup after reset deassertion misses.
- There is no stall input. The caller gates UPD_VALID with its stall so that each resolved instruction is reported exactly once.
- All outputs are defined (no X) after the first reset edge.
- Implementation: flop array, or distributed RAM with asynchronous read. Valid bits must be flops so that single-cycle clear works.

Test Plan:
- Reset then cold lookup: RESET 1 cycle, F_PC=0x100 -> PRED_TAKEN=0, PRED_TARGET=0, both PERF=0.
- Allocate and train: update PC=0x100 taken target 0x180 (conditional). Next cycle F_PC=0x100 -> PRED_TAKEN=1, PRED_TARGET=0x180. Two not-taken updates -> PRED_TAKEN=0 (counter 2->1->0). Three more not-taken updates keep the counter at 0 (saturation).
- Tag conflict (ENTRIES=16): PC=0x100 allocated; taken update PC=0x140 target 0x200 (same index 0) -> F_PC=0x100 misses, F_PC=0x140 predicts 0x200. A not-taken miss at PC=0x180 leaves the entry unchanged.
- Unconditional: UPD_UNCOND=1, PC=0x20, target 0x3C -> counter=3. One not-taken conditional update at 0x20 -> still predicts taken (counter 2).
- Simultaneous events: lookup and update at the same index in the same cycle returns the old value. FLUSH with UPD_VALID -> all lookups miss next cycle, and PERF_BRANCHES still increments.
- Perf saturation (PERF_W=4): 20 updates with UPD_MISPRED=1 -> both counters hold 4'hF. RESET mid-stream -> 0 next cycle, and the concurrent update is discarded.
